// File: rtl/fir_mc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_mc_serial : single-MAC, time-multiplexed multi-channel FIR filter with   |
// |                 per-channel circular history and ping-pong coefficient banks |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module fir_mc_serial #(
   parameter int  DATA_W    = 24,
   parameter int  COEF_W    = 18,
   parameter int  TAPS      = 128,
   parameter int  CHANNELS  = 4,
   parameter int  OUT_SHIFT = 17,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int TAP_W     = $clog2(TAPS)
) (
   input  logic              s_axis_aclk,
   input  logic              s_axis_arstn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [CH_W-1:0]   s_axis_tuser,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [CH_W-1:0]   m_axis_tuser,
   output logic              m_axis_tlast,
   input  logic              cfg_wr,
   input  logic [TAP_W-1:0]  cfg_addr,
   input  logic [COEF_W-1:0] cfg_data,
   input  logic              cfg_commit,
   output logic              cfg_pending,
   output logic              sat_flag,
   input  logic              sat_clr
);

   localparam int ACC_W  = DATA_W + COEF_W + TAP_W;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int MEM_D  = CHANNELS * TAPS;
   localparam int ADDR_W = $clog2(MEM_D);

   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] RND_C = {{(ACC_W-1){1'b0}}, 1'b1} << (OUT_SHIFT-1);

   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_MAC   = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [ADDR_W-1:0]        clr_q, clr_d;
   logic [TAP_W-1:0]         k_q, k_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic                     last_q, last_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0]        m_data_q, m_data_d;
   logic                     m_valid_q, m_valid_d;
   logic [CH_W-1:0]          m_user_q, m_user_d;
   logic                     m_last_q, m_last_d;
   logic                     sel_q, sel_d;
   logic                     pend_q, pend_d;
   logic                     sat_q, sat_d;
   logic [TAP_W-1:0]         wp_q [CHANNELS];
   logic signed [COEF_W-1:0] bank_q [2][TAPS];
   logic signed [DATA_W-1:0] mem_q [MEM_D];

   logic                     w_hs, w_ch_ok, w_swap, w_sat;
   logic [TAP_W-1:0]         w_tap;
   logic [ADDR_W-1:0]        w_rd_addr, w_wr_addr;
   logic signed [DATA_W-1:0] w_x;
   logic signed [COEF_W-1:0] w_coef;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext, w_rnd, w_shr;
   logic [DATA_W-1:0]        w_y;

   assign w_hs      = s_axis_tvalid && (state_q == S_IDLE);
   assign w_ch_ok   = {{(32-CH_W){1'b0}}, s_axis_tuser} < 32'(CHANNELS);
   assign w_swap    = (state_q == S_IDLE) && pend_q;

   // Newest sample of the channel sits at wp; tap k looks k entries back.
   assign w_tap     = wp_q[ch_q] - k_q;
   assign w_rd_addr = ADDR_W'({ch_q, w_tap});
   assign w_wr_addr = ADDR_W'({s_axis_tuser, wp_q[s_axis_tuser]});
   assign w_x       = mem_q[w_rd_addr];
   assign w_coef    = bank_q[sel_q][k_q];
   assign w_prod    = w_x * w_coef;
   assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

   assign w_rnd     = acc_q + RND_C;
   assign w_shr     = w_rnd >>> OUT_SHIFT;
   assign w_sat     = (w_shr > MAX_V) || (w_shr < MIN_V);
   assign w_y       = (w_shr > MAX_V) ? MAX_V[DATA_W-1:0] :
                      (w_shr < MIN_V) ? MIN_V[DATA_W-1:0] : w_shr[DATA_W-1:0];

   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      k_d       = k_q;
      ch_d      = ch_q;
      last_d    = last_q;
      acc_d     = acc_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_user_d  = m_user_q;
      m_last_d  = m_last_q;
      sel_d     = sel_q ^ w_swap;
      pend_d    = w_swap ? 1'b0 : (pend_q | cfg_commit);
      sat_d     = sat_q & ~sat_clr;
      case (state_q)
         S_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == ADDR_W'(MEM_D-1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            // Samples for nonexistent channels are consumed and discarded.
            if (w_hs && w_ch_ok) begin
               ch_d    = s_axis_tuser;
               last_d  = s_axis_tlast;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + w_prod_ext;
            k_d   = k_q + 1'b1;
            if (k_q == TAP_W'(TAPS-1)) state_d = S_ROUND;
         end
         S_ROUND: begin
            m_data_d  = w_y;
            m_user_d  = ch_q;
            m_last_d  = last_q;
            m_valid_d = 1'b1;
            if (w_sat) sat_d = 1'b1;
            state_d   = S_OUT;
         end
         S_OUT: begin
            if (m_axis_tready) begin
               m_valid_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn) begin
         state_q   <= S_CLEAR;
         clr_q     <= '0;
         k_q       <= '0;
         ch_q      <= '0;
         last_q    <= 1'b0;
         acc_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_user_q  <= '0;
         m_last_q  <= 1'b0;
         sel_q     <= 1'b0;
         pend_q    <= 1'b0;
         sat_q     <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) wp_q[c] <= '0;
      end else begin
         state_q   <= state_d;
         clr_q     <= clr_d;
         k_q       <= k_d;
         ch_q      <= ch_d;
         last_q    <= last_d;
         acc_q     <= acc_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_user_q  <= m_user_d;
         m_last_q  <= m_last_d;
         sel_q     <= sel_d;
         pend_q    <= pend_d;
         sat_q     <= sat_d;
         if (state_q == S_ROUND) wp_q[ch_q] <= wp_q[ch_q] + 1'b1;
      end
   end

   // Shadow bank is always the one not selected for the MAC.
   always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn) begin
         for (int b = 0; b < 2; b++)
            for (int t = 0; t < TAPS; t++) bank_q[b][t] <= '0;
      end else if (cfg_wr) begin
         bank_q[~sel_q][cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (state_q == S_CLEAR)     mem_q[clr_q]     <= '0;
      else if (w_hs && w_ch_ok)   mem_q[w_wr_addr] <= s_axis_tdata;
   end

   assign s_axis_tready = (state_q == S_IDLE);
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tuser  = m_user_q;
   assign m_axis_tlast  = m_last_q;
   assign cfg_pending   = pend_q;
   assign sat_flag      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_mc_serial : directed self-checking bench for fir_mc_serial            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_fir_mc_serial;
   localparam int DATA_W = 24, COEF_W = 18, TAPS = 128, CHANNELS = 4, OUT_SHIFT = 17;
   localparam int CH_W = 2, TAP_W = 7, LIM = 2000;
   // 1<<17 does not fit an 18-bit signed coefficient; 2^17-1 acts as unity gain.
   localparam int UNITY = 131071;

   logic              clk = 1'b0;
   logic              arstn;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid, s_tready, s_tlast;
   logic [CH_W-1:0]   s_tuser;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid, m_tready, m_tlast;
   logic [CH_W-1:0]   m_tuser;
   logic              cfg_wr, cfg_commit, cfg_pending, sat_flag, sat_clr;
   logic [TAP_W-1:0]  cfg_addr;
   logic [COEF_W-1:0] cfg_data;

   int n_chk = 0, n_fail = 0, cyc = 0, h_cyc = 0;

   fir_mc_serial #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
                   .CHANNELS(CHANNELS), .OUT_SHIFT(OUT_SHIFT)) dut (
      .s_axis_aclk(clk), .s_axis_arstn(arstn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
      .sat_flag(sat_flag), .sat_clr(sat_clr));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_bank(input int idx, input int val);
      cfg_wr = 1'b1;
      for (int k = 0; k < TAPS; k++) begin
         cfg_addr = TAP_W'(k);
         cfg_data = (idx < 0 || k == idx) ? COEF_W'(val) : '0;
         tick();
      end
      cfg_wr = 1'b0;
   endtask

   task automatic commit_idle();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check("pending_set", cfg_pending, 1);
      tick();
      check("pending_swap_idle", cfg_pending, 0);
   endtask

   task automatic send(input int ch, input int x, input bit last, input bit chk_pend);
      int g = 0;
      s_tuser = CH_W'(ch); s_tdata = DATA_W'(x); s_tlast = last; s_tvalid = 1'b1;
      while (!s_tready && g < LIM) begin tick(); g++; end
      if (g >= LIM) begin
         n_chk++; n_fail++;
         $error("FAIL send_timeout: observed tready=0 expected tready=1");
      end
      if (chk_pend) check("pending_before_accept", cfg_pending, 1);
      @(posedge clk);
      #1;
      h_cyc = cyc;
      s_tvalid = 1'b0;
      if (chk_pend) check("pending_after_accept", cfg_pending, 0);
   endtask

   task automatic get_out(input int exp_d, input int exp_u, input bit exp_l,
                          input bit chk_lat, input string tag);
      int g = 0;
      while (!m_tvalid && g < LIM) begin tick(); g++; end
      if (g >= LIM) begin
         n_chk++; n_fail++;
         $error("FAIL %s_timeout: observed tvalid=0 expected tvalid=1", tag);
      end
      if (chk_lat) check({tag, "_latency"}, cyc - h_cyc, TAPS + 1);
      check({tag, "_data"}, $signed(m_tdata), exp_d);
      check({tag, "_user"}, m_tuser, exp_u);
      check({tag, "_last"}, m_tlast, exp_l);
      if (m_tready) begin
         tick();
         check({tag, "_valid_drop"}, m_tvalid, 0);
      end
   endtask

   task automatic count_clear();
      int n = 0;
      while (!s_tready && n < LIM) begin tick(); n++; end
      check("clear_cycles", n, CHANNELS * TAPS);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      arstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tuser = '0; s_tlast = 1'b0;
      m_tready = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_commit = 1'b0; sat_clr = 1'b0;

      // Reset values and CLEAR duration.
      repeat (3) tick();
      check("rst_tready", s_tready, 0);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tuser", m_tuser, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_pending", cfg_pending, 0);
      check("rst_sat", sat_flag, 0);
      arstn = 1'b1;
      count_clear();

      // Single-tap unity: output equals input, latency TAPS+1 edges after accept.
      fill_bank(0, UNITY);
      commit_idle();
      send(0, 1000, 1'b1, 1'b0);
      get_out(1000, 0, 1'b1, 1'b1, "unity");

      // Tap 5 only: ch1 impulse emerges 5 samples later; ch0 keeps its own
      // history, so its earlier 1000 (written at wp=0) reappears at wp=5.
      fill_bank(5, UNITY);
      commit_idle();
      for (int i = 0; i < 6; i++) begin
         send(1, (i == 0) ? 4096 : 0, 1'b0, 1'b0);
         get_out((i == 5) ? 4096 : 0, 1, 1'b0, 1'b1, "tap5_ch1");
         send(0, 0, 1'b0, 1'b0);
         get_out((i == 4) ? 1000 : 0, 0, 1'b0, 1'b1, "tap5_ch0");
      end

      // All taps near-unity: accumulate until clipping in both directions.
      fill_bank(-1, UNITY);
      commit_idle();
      send(1, -8388608, 1'b0, 1'b0);
      get_out(-8384448, 1, 1'b0, 1'b1, "neg_nosat");
      check("sat_neg_before", sat_flag, 0);
      send(1, -8388608, 1'b0, 1'b0);
      get_out(-8388608, 1, 1'b0, 1'b1, "neg_sat");
      check("sat_neg_after", sat_flag, 1);
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      check("sat_clr", sat_flag, 0);
      send(2, 8388607, 1'b0, 1'b0);
      get_out(8388543, 2, 1'b0, 1'b1, "pos_nosat");
      check("sat_pos_before", sat_flag, 0);
      send(2, 8388607, 1'b0, 1'b0);
      get_out(8388607, 2, 1'b0, 1'b1, "pos_sat");
      check("sat_pos_after", sat_flag, 1);
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      check("sat_clr2", sat_flag, 0);
      // sat_clr in the very cycle a new clip is detected.
      send(2, 8388607, 1'b0, 1'b0);
      repeat (TAPS) tick();
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      check("sat_clr_vs_set", sat_flag, 1);
      get_out(8388607, 2, 1'b0, 1'b1, "pos_sat2");

      // Commit during MAC: sample N keeps the old bank, N+1 gets the new one.
      fill_bank(0, -131072);
      send(3, 1000, 1'b0, 1'b0);
      repeat (10) tick();
      cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
      check("pending_in_mac", cfg_pending, 1);
      cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
      check("pending_double_commit", cfg_pending, 1);
      get_out(1000, 3, 1'b0, 1'b1, "old_bank");
      send(3, 2000, 1'b1, 1'b1);
      get_out(-2000, 3, 1'b1, 1'b1, "new_bank");

      // Backpressure: output held stable while the sink stalls.
      m_tready = 1'b0;
      send(0, 300, 1'b1, 1'b0);
      get_out(-300, 0, 1'b1, 1'b1, "stall");
      for (int i = 0; i < 50; i++) begin
         tick();
         check("stall_valid", m_tvalid, 1);
         check("stall_data", $signed(m_tdata), -300);
         check("stall_in_ready", s_tready, 0);
      end
      m_tready = 1'b1;
      tick();
      check("stall_release", m_tvalid, 0);

      // Asynchronous reset while an output is waiting.
      m_tready = 1'b0;
      send(0, 50, 1'b0, 1'b0);
      get_out(-50, 0, 1'b0, 1'b1, "pre_reset");
      cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
      check("pending_in_out", cfg_pending, 1);
      #2 arstn = 1'b0;
      #1;
      check("async_rst_valid", m_tvalid, 0);
      check("async_rst_data", m_tdata, 0);
      check("async_rst_pending", cfg_pending, 0);
      check("async_rst_ready", s_tready, 0);
      m_tready = 1'b1;
      tick(); tick();
      arstn = 1'b1;
      count_clear();
      // Banks and history are zero again.
      send(0, 777, 1'b0, 1'b0);
      get_out(0, 0, 1'b0, 1'b1, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
